// File: rtl/id_hazard_ctrl.sv
// Hazard and stage-tracking control for the five-stage pipeline.
// Ports: ID fields in, per-stage rd/finish flags and stall/flush/freeze controls out.
module id_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic [1:0]       id_wb_sel,
  input  logic             id_store,
  input  logic             id_branch_taken,
  input  logic             mem_ack,
  output logic [4:0]       ID_EX_rd,
  output logic [4:0]       EX_MEM_rd,
  output logic [4:0]       MEM_WB_rd,
  output logic             ex_ex_finish,
  output logic             mem_ex_finish,
  output logic             mem_mem_finish,
  output logic             mem_req,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LIM =
    WC_W'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [1:0] wb;
    logic       st;
  } trk_t;

  typedef enum logic [1:0] {
    M_IDLE,
    M_WAIT,
    M_ERR
  } mstate_e;

  trk_t ex_q, ex_d;
  trk_t mem_q, mem_d;
  trk_t wb_q, wb_d;
  trk_t id_t;

  mstate_e         st_q, st_d;
  logic [WC_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q;

  logic ack;
  logic mem_hold;
  logic rs1_ld, rs2_ld;
  logic ld_use;

  function automatic logic is_mop(trk_t t);
    return t.v && ((t.wb == 2'b10) || t.st);
  endfunction

  function automatic logic [4:0] rd_of(trk_t t);
    return (t.v && t.wb != 2'b00 && !t.st)
      ? t.rd : 5'd0;
  endfunction

  function automatic logic alu_fin(trk_t t);
    return t.v && !t.st &&
      (t.wb == 2'b01 || t.wb == 2'b11);
  endfunction

  function automatic logic ld_hit(
    logic [4:0] rs, trk_t t);
    return t.v && !t.st &&
      t.wb == 2'b10 && rs == t.rd;
  endfunction

  always_comb begin
    id_t    = '0;
    id_t.v  = id_valid;
    id_t.rd = id_rd;
    id_t.wb = id_wb_sel;
    id_t.st = id_store;
  end

  // An ack only counts while a request is
  // actually outstanding.
  assign mem_req  = is_mop(mem_q) && st_q != M_ERR;
  assign ack      = mem_ack && mem_req;
  assign mem_hold = (is_mop(mem_q) && !ack) ||
                    st_q == M_ERR;

  assign rs1_ld = id_use_rs1 &&
    IF_ID_rs1 != 5'd0 &&
    (ld_hit(IF_ID_rs1, ex_q) ||
     (ld_hit(IF_ID_rs1, mem_q) && !ack));
  assign rs2_ld = id_use_rs2 &&
    IF_ID_rs2 != 5'd0 &&
    (ld_hit(IF_ID_rs2, ex_q) ||
     (ld_hit(IF_ID_rs2, mem_q) && !ack));
  assign ld_use = id_valid && (rs1_ld || rs2_ld);

  assign pipe_freeze  = mem_hold;
  assign pc_stall     = mem_hold || ld_use;
  assign if_id_stall  = mem_hold || ld_use;
  assign id_ex_bubble = !mem_hold && ld_use;
  assign if_id_flush  = !mem_hold && !ld_use &&
                        id_valid && id_branch_taken;

  assign ID_EX_rd       = rd_of(ex_q);
  assign EX_MEM_rd      = rd_of(mem_q);
  assign MEM_WB_rd      = rd_of(wb_q);
  assign ex_ex_finish   = alu_fin(ex_q);
  assign mem_ex_finish  = alu_fin(mem_q);
  assign mem_mem_finish = mem_q.v && !mem_q.st &&
                          mem_q.wb == 2'b10 && ack;

  assign mem_err   = st_q == M_ERR;
  assign stall_cnt = cnt_q;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (mem_hold) begin
      wb_d.v = 1'b0;
    end else if (ld_use) begin
      ex_d.v = 1'b0;
      mem_d  = ex_q;
      wb_d   = mem_q;
    end else begin
      ex_d  = id_t;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  always_comb begin
    st_d   = st_q;
    wait_d = wait_q;
    case (st_q)
      M_IDLE: begin
        wait_d = '0;
        if (mem_req && !mem_ack)
          st_d = M_WAIT;
      end
      M_WAIT: begin
        if (mem_ack) begin
          st_d   = M_IDLE;
          wait_d = '0;
        end else if (wait_q == WC_LIM) begin
          st_d = M_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      M_ERR: begin
        st_d = M_ERR;
      end
      default: begin
        st_d   = M_IDLE;
        wait_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= M_IDLE;
      wait_q <= '0;
    end else begin
      st_q   <= st_d;
      wait_q <= wait_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      if (pc_stall && !(&cnt_q))
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed self-checking bench for id_hazard_ctrl.
// Drives ID fields and mem_ack per cycle, checks mid-cycle.
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic [4:0]  id_rd;
  logic [1:0]  id_wb_sel;
  logic        id_store;
  logic        id_branch_taken;
  logic        mem_ack;
  logic [4:0]  ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
  logic        ex_ex_finish, mem_ex_finish;
  logic        mem_mem_finish, mem_req;
  logic        pc_stall, if_id_stall, if_id_flush;
  logic        id_ex_bubble, pipe_freeze, mem_err;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  id_hazard_ctrl #(
    .MEM_TIMEOUT(8),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_valid(id_valid),
    .IF_ID_rs1(IF_ID_rs1),
    .IF_ID_rs2(IF_ID_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .id_rd(id_rd),
    .id_wb_sel(id_wb_sel),
    .id_store(id_store),
    .id_branch_taken(id_branch_taken),
    .mem_ack(mem_ack),
    .ID_EX_rd(ID_EX_rd),
    .EX_MEM_rd(EX_MEM_rd),
    .MEM_WB_rd(MEM_WB_rd),
    .ex_ex_finish(ex_ex_finish),
    .mem_ex_finish(mem_ex_finish),
    .mem_mem_finish(mem_mem_finish),
    .mem_req(mem_req),
    .pc_stall(pc_stall),
    .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .pipe_freeze(pipe_freeze),
    .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v,
                        input logic [4:0] rs1,
                        input logic [4:0] rs2,
                        input logic u1,
                        input logic u2,
                        input logic [4:0] rd,
                        input logic [1:0] wb,
                        input logic st,
                        input logic br);
    id_valid        = v;
    IF_ID_rs1       = rs1;
    IF_ID_rs2       = rs2;
    id_use_rs1      = u1;
    id_use_rs2      = u2;
    id_rd           = rd;
    id_wb_sel       = wb;
    id_store        = st;
    id_branch_taken = br;
  endtask

  task automatic id_nop;
    id_set(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic drain;
    id_nop();
    mem_ack = 1'b0;
    repeat (3) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},
        {17'd0, ID_EX_rd, EX_MEM_rd, MEM_WB_rd}, 0);
    chk({tag, "_fin"},
        {29'd0, ex_ex_finish, mem_ex_finish,
         mem_mem_finish}, 0);
    chk({tag, "_ctl"},
        {25'd0, mem_req, pc_stall, if_id_stall,
         if_id_flush, id_ex_bubble, pipe_freeze,
         mem_err}, 0);
    chk({tag, "_cnt"}, stall_cnt, 0);
  endtask

  initial begin
    rst     = 1'b1;
    mem_ack = 1'b0;
    id_nop();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk_all_zero("reset");

    // ALU chain
    id_set(1, 1, 2, 1, 1, 5, 2'b01, 0, 0);
    #1 chk("alu_nostall0", pc_stall, 0);
    tick();
    id_set(1, 5, 5, 1, 1, 9, 2'b01, 0, 0);
    #1;
    chk("alu_ex_rd", ID_EX_rd, 5);
    chk("alu_ex_fin", ex_ex_finish, 1);
    chk("alu_nostall1", pc_stall, 0);
    tick();
    id_nop();
    #1;
    chk("alu_mem_rd", EX_MEM_rd, 5);
    chk("alu_mem_fin", mem_ex_finish, 1);
    chk("alu_ex_rd9", ID_EX_rd, 9);
    chk("alu_no_req", mem_req, 0);
    tick();
    #1 chk("alu_wb_rd", MEM_WB_rd, 5);
    drain();
    chk("alu_cnt", stall_cnt, 0);

    // load-use, ack in first MEM cycle
    id_set(1, 1, 0, 1, 0, 6, 2'b10, 0, 0);
    tick();
    id_set(1, 6, 0, 1, 0, 7, 2'b01, 0, 0);
    #1;
    chk("lu_pc_stall", pc_stall, 1);
    chk("lu_ifid_stall", if_id_stall, 1);
    chk("lu_bubble", id_ex_bubble, 1);
    chk("lu_ex_rd", ID_EX_rd, 6);
    chk("lu_nofreeze", pipe_freeze, 0);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_released", pc_stall, 0);
    chk("lu_mm_fin", mem_mem_finish, 1);
    chk("lu_mem_rd", EX_MEM_rd, 6);
    chk("lu_bubble_rd", ID_EX_rd, 0);
    tick();
    id_nop();
    mem_ack = 1'b0;
    #1;
    chk("lu_add_ex", ID_EX_rd, 7);
    chk("lu_wb_rd", MEM_WB_rd, 6);
    chk("lu_req_off", mem_req, 0);
    drain();

    // multi-cycle memory, ack after 3 wait cycles
    id_set(1, 1, 0, 1, 0, 10, 2'b10, 0, 0);
    tick();
    id_nop();
    #1 chk("mc_nostall", pc_stall, 0);
    tick();
    id_set(1, 2, 0, 1, 0, 11, 2'b01, 0, 0);
    #1;
    chk("mc_req0", mem_req, 1);
    chk("mc_frz0", pipe_freeze, 1);
    chk("mc_stall0", pc_stall, 1);
    chk("mc_nobub0", id_ex_bubble, 0);
    tick();
    #1;
    chk("mc_req1", mem_req, 1);
    chk("mc_frz1", pipe_freeze, 1);
    tick();
    #1 chk("mc_frz2", pipe_freeze, 1);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("mc_mm_fin", mem_mem_finish, 1);
    chk("mc_unfrz", pipe_freeze, 0);
    chk("mc_mem_rd", EX_MEM_rd, 10);
    chk("mc_cnt", stall_cnt, 4);
    tick();
    id_nop();
    mem_ack = 1'b0;
    #1;
    chk("mc_wb_rd", MEM_WB_rd, 10);
    chk("mc_ex_rd", ID_EX_rd, 11);
    chk("mc_req_off", mem_req, 0);
    drain();

    // x0 destination and unused operand
    id_set(1, 1, 0, 1, 0, 0, 2'b10, 0, 0);
    tick();
    id_set(1, 0, 0, 1, 0, 12, 2'b01, 0, 0);
    #1 chk("x0_nostall", pc_stall, 0);
    tick();
    id_nop();
    mem_ack = 1'b1;
    #1;
    chk("x0_req", mem_req, 1);
    chk("x0_mem_rd", EX_MEM_rd, 0);
    tick();
    mem_ack = 1'b0;
    id_set(1, 1, 0, 1, 0, 8, 2'b10, 0, 0);
    tick();
    id_set(1, 8, 3, 0, 1, 9, 2'b01, 0, 0);
    #1;
    chk("unused_nostall", pc_stall, 0);
    chk("unused_nobub", id_ex_bubble, 0);
    tick();
    id_nop();
    mem_ack = 1'b1;
    #1 chk("lw8_mm_fin", mem_mem_finish, 1);
    tick();
    drain();

    // taken branch during load-use
    id_set(1, 1, 0, 1, 0, 13, 2'b10, 0, 0);
    tick();
    id_set(1, 13, 0, 1, 0, 0, 2'b00, 0, 1);
    #1;
    chk("br_noflush", if_id_flush, 0);
    chk("br_bubble", id_ex_bubble, 1);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("br_flush", if_id_flush, 1);
    chk("br_nostall", pc_stall, 0);
    tick();
    id_nop();
    mem_ack = 1'b0;
    #1 chk("br_cnt", stall_cnt, 5);
    drain();

    // store never reports a destination
    id_set(1, 1, 13, 1, 1, 14, 2'b00, 1, 0);
    tick();
    id_nop();
    #1;
    chk("st_ex_rd", ID_EX_rd, 0);
    chk("st_ex_fin", ex_ex_finish, 0);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("st_req", mem_req, 1);
    chk("st_mem_rd", EX_MEM_rd, 0);
    chk("st_mm_fin", mem_mem_finish, 0);
    chk("st_me_fin", mem_ex_finish, 0);
    tick();
    drain();

    // stray ack with nothing outstanding
    mem_ack = 1'b1;
    #1;
    chk("stray_fin", mem_mem_finish, 0);
    chk("stray_req", mem_req, 0);
    tick();
    mem_ack = 1'b0;
    #1 chk("stray_nostall", pc_stall, 0);

    // timeout then reset
    id_set(1, 1, 0, 1, 0, 15, 2'b10, 0, 0);
    tick();
    id_nop();
    tick();
    #1;
    chk("to_req0", mem_req, 1);
    chk("to_err0", mem_err, 0);
    tick();
    #1 chk("to_err1", mem_err, 0);
    repeat (8) tick();
    #1;
    chk("to_err", mem_err, 1);
    chk("to_req_off", mem_req, 0);
    chk("to_frz", pipe_freeze, 1);
    chk("to_stall", pc_stall, 1);
    mem_ack = 1'b1;
    #1 chk("to_ack_ign", mem_mem_finish, 0);
    tick();
    #1 chk("to_sticky", mem_err, 1);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk_all_zero("rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Hazard and stage-tracking controller for the five-stage pipeline; the ID-stage operand-forwarding mux consumes its outputs.
- Shadows destination-register and writeback-type information through EX, MEM and WB.
- Produces the per-stage rd and "result finished" flags the forwarding mux uses.
- Generates stall, flush and bubble controls for load-use hazards, ID-resolved taken branches and multi-cycle data-memory accesses.

Parameters:
MEM_TIMEOUT, 64, max cycles a data-memory request may wait for mem_ack before mem_err is raised
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  valid instruction in ID
IF_ID_rs1  in  5  ID source register 1
IF_ID_rs2  in  5  ID source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_rd  in  5  ID destination register
id_wb_sel  in  2  00 none, 01 ALU, 10 load, 11 PC+4 (treated as ALU)
id_store  in  1  ID instruction is a store
id_branch_taken  in  1  branch/jump resolved taken in ID
mem_ack  in  1  data memory completes the current request this cycle (load data valid same cycle)
ID_EX_rd  out  5  rd of EX instruction, 0 if invalid or non-writing
EX_MEM_rd  out  5  rd of MEM instruction, 0 if invalid or non-writing
MEM_WB_rd  out  5  rd of WB instruction, 0 if invalid or non-writing
ex_ex_finish  out  1  EX instruction valid, ALU/PC+4 writeback
mem_ex_finish  out  1  MEM instruction valid, ALU/PC+4 writeback
mem_mem_finish  out  1  MEM instruction is a load and mem_ack=1 this cycle
mem_req  out  1  data-memory request strobe (level)
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  clear IF/ID register
id_ex_bubble  out  1  load NOP into ID/EX
pipe_freeze  out  1  hold ID/EX and EX/MEM; MEM/WB takes bubble
mem_err  out  1  sticky timeout error
stall_cnt  out  CNT_W  cycles with pc_stall=1

Behaviour:
- Tracking registers per stage (EX, MEM, WB): valid, rd, wb_sel, memop (load or store).
- Reset: all tracking valid=0, rd=0, wb_sel=0; FSM M_IDLE; wait_cnt=0; stall_cnt=0; mem_err=0.
- Consequence of reset: every rd and finish output is 0, and mem_req, all stall/flush/bubble controls and pipe_freeze are 0.
- mem_hold = MEM valid & memop & !mem_ack, or FSM in M_ERR.
- ld_use is evaluated per used source register rs (rs != 0):
  - (EX valid & rs==ex_rd & ex wb_sel==load), or
  - (MEM valid & rs==mem_rd & mem wb_sel==load & !mem_ack).
  - ld_use is gated by id_valid.
- Priority 1, mem_hold:
  - pc_stall=if_id_stall=pipe_freeze=1.
  - WB valid <= 0; EX and MEM regs hold.
  - if_id_flush=0 and id_ex_bubble=0.
- Priority 2, ld_use (no mem_hold):
  - pc_stall=if_id_stall=id_ex_bubble=1, so EX valid <= 0.
  - MEM <= EX, WB <= MEM.
  - if_id_flush=0; the branch is re-evaluated next cycle.
- Priority 3, id_valid & id_branch_taken: if_id_flush=1; normal advance.
- Normal advance: EX <= ID fields (valid=id_valid), MEM <= EX, WB <= MEM.
- mem_req = MEM valid & memop & FSM != M_ERR.
  - Held high until the mem_ack cycle.
  - The stage advances on the ack edge.
  - Back-to-back memops issue a new request the following cycle.
- FSM:
  - M_IDLE -> M_WAIT when mem_req & !mem_ack.
  - M_WAIT -> M_IDLE on mem_ack.
  - M_WAIT -> M_ERR when wait_cnt reaches MEM_TIMEOUT-1 without ack.
  - M_ERR stays until rst; mem_err=1 in M_ERR.
- wait_cnt: cleared in M_IDLE, increments in M_WAIT.
- mem_ack while mem_req=0: ignored.
- Reset during M_WAIT: mem_req drops the cycle after the reset edge; the in-flight access is abandoned.
- stall_cnt increments when pc_stall=1 and saturates at all-ones.
- Finish flags are purely combinational from tracking regs and mem_ack.
- A store in MEM never asserts mem_ex_finish or mem_mem_finish, and its rd output is 0.

Test Plan:
- ALU chain: add x5 followed by use of x5 -> ID_EX_rd=5, ex_ex_finish=1; no stall; next cycle EX_MEM_rd=5, mem_ex_finish=1.
- Load-use, ack in 1 cycle: lw x6 then add x7,x6 -> exactly one cycle with pc_stall=id_ex_bubble=1, stall_cnt=1. Next cycle mem_mem_finish=1, EX_MEM_rd=6, and the add proceeds.
- Multi-cycle memory: lw in MEM, mem_ack delayed 3 cycles -> mem_req=1 and pipe_freeze=1 for 3 cycles, FSM M_WAIT. Ack cycle mem_mem_finish=1; MEM_WB_rd=lw rd the next cycle.
- x0 and unused operands: lw x0 then use of x0, and lw x8 followed by an instruction with id_use_rs1=0 reading rs1=8 -> no stall.
- Branch versus stall: id_branch_taken=1 during ld_use -> if_id_flush=0 that cycle. Flush asserts the following cycle once ld_use clears.
- Timeout and reset: no mem_ack for MEM_TIMEOUT cycles -> mem_err=1, mem_req=0, pipe frozen. rst=1 for one cycle -> all outputs 0, stall_cnt=0.
